// File: rtl/dsp_stream_pkg.sv
// Shared widths and types for the DSP result stream between the core and its sinks.
package dsp_stream_pkg;

  localparam int DSP_DATA_W = 32;
  localparam int DSP_TAG_W  = 5;

  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef struct packed {
    logic [DSP_TAG_W-1:0]  tag;
    logic [DSP_DATA_W-1:0] data;
  } dsp_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Counter-based synchronous FIFO, first-word-fall-through read port.
module sync_fifo #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage is intentionally left unreset; only pointers and count define contents.
  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/dsp_sample_drain.sv
// Captures DSP write-back results into a FIFO and streams them out with frame
// markers and sticky overflow / saturating drop accounting.
module dsp_sample_drain
  import dsp_stream_pkg::*;
#(
  parameter int DATA_W    = DSP_DATA_W,
  parameter int TAG_W     = DSP_TAG_W,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cap_valid,
  input  logic [DATA_W-1:0]         cap_data,
  input  logic [TAG_W-1:0]          cap_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_last,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_cnt,
  input  logic                      clear_ovf
);

  localparam int ENT_W = TAG_W + DATA_W;
  localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  logic [ENT_W-1:0] w_rd_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [FC_W-1:0]  r_frame_cnt;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  // Full is the pre-edge value, so a capture while full drops even if a pop frees a slot.
  assign w_push = cap_valid & ~w_full;
  assign w_drop = cap_valid &  w_full;
  assign w_pop  = ~w_empty & out_ready;

  sync_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (w_push),
    .wr_data ({cap_tag, cap_data}),
    .pop     (w_pop),
    .rd_data (w_rd_entry),
    .count   (count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_pop) begin
      r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
    end
  end

  // A drop on the same edge as clear_ovf wins and restarts the tally at one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_ovf)                  r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign out_valid = ~w_empty;
  assign out_data  = w_rd_entry[DATA_W-1:0];
  assign out_tag   = w_rd_entry[ENT_W-1:DATA_W];
  assign out_last  = ~w_empty & (r_frame_cnt == FC_LAST);
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_dsp_sample_drain.sv
// Directed bench for dsp_sample_drain: two instances share stimulus, one with
// 4-sample frames and one with 16-sample frames.
module tb_dsp_sample_drain;

  logic        clock = 1'b0;
  logic        reset;
  logic        cap_valid;
  logic [31:0] cap_data;
  logic [4:0]  cap_tag;
  logic        out_ready;
  logic        clear_ovf;

  logic        a_valid, a_last, a_full, a_ovf;
  logic [31:0] a_data;
  logic [4:0]  a_tag;
  logic [3:0]  a_count;
  logic [7:0]  a_drop;

  logic        b_valid, b_last, b_full, b_ovf;
  logic [31:0] b_data;
  logic [4:0]  b_tag;
  logic [3:0]  b_count;
  logic [7:0]  b_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  dsp_sample_drain #(.DATA_W(32), .TAG_W(5), .DEPTH(8), .FRAME_LEN(4)) u_dut (
    .clock(clock), .reset(reset), .cap_valid(cap_valid), .cap_data(cap_data),
    .cap_tag(cap_tag), .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_tag(a_tag), .out_last(a_last), .full(a_full), .count(a_count),
    .overflow(a_ovf), .drop_cnt(a_drop), .clear_ovf(clear_ovf)
  );

  dsp_sample_drain #(.DATA_W(32), .TAG_W(5), .DEPTH(8), .FRAME_LEN(16)) u_dut16 (
    .clock(clock), .reset(reset), .cap_valid(cap_valid), .cap_data(cap_data),
    .cap_tag(cap_tag), .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_tag(b_tag), .out_last(b_last), .full(b_full), .count(b_count),
    .overflow(b_ovf), .drop_cnt(b_drop), .clear_ovf(clear_ovf)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cap_valid = 1'b0; cap_data = '0; cap_tag = '0;
    out_ready = 1'b0; clear_ovf = 1'b0;
    #12;
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b exp 0", a_valid); end
    n_checks++; if (a_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %0b exp 0", a_full); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", a_count); end
    n_checks++; if (a_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %0b exp 0", a_last); end
    n_checks++; if (a_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %0b exp 0", a_ovf); end
    n_checks++; if (a_drop !== 8'd0) begin n_errors++; $display("FAIL reset_drop: got %0d exp 0", a_drop); end
    n_checks++; if (b_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid16: got %0b exp 0", b_valid); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'b1; cap_data = 32'((i + 1) * 10); cap_tag = 5'b00011;
      step();
      n_checks++; if (a_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid[%0d]: got %0b exp 1", i, a_valid); end
      n_checks++; if (a_data !== 32'((i + 1) * 10)) begin n_errors++; $display("FAIL basic_data[%0d]: got %0d exp %0d", i, a_data, (i + 1) * 10); end
      n_checks++; if (a_tag !== 5'b00011) begin n_errors++; $display("FAIL basic_tag[%0d]: got %0d exp 3", i, a_tag); end
      n_checks++; if (a_last !== (i == 3)) begin n_errors++; $display("FAIL basic_last[%0d]: got %0b exp %0b", i, a_last, (i == 3)); end
    end
    cap_valid = 1'b0;
    step();
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL basic_empty: got %0b exp 0", a_valid); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL basic_count: got %0d exp 0", a_count); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cap_valid = 1'b1; cap_data = 32'(100 + i); cap_tag = 5'(i);
      step();
      if (i == 7) begin
        n_checks++; if (a_full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %0b exp 1", a_full); end
        n_checks++; if (a_count !== 4'd8) begin n_errors++; $display("FAIL ovf_count: got %0d exp 8", a_count); end
      end
    end
    cap_valid = 1'b0;
    n_checks++; if (a_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %0b exp 1", a_ovf); end
    n_checks++; if (a_drop !== 8'd2) begin n_errors++; $display("FAIL ovf_drop: got %0d exp 2", a_drop); end
    n_checks++; if (a_count !== 4'd8) begin n_errors++; $display("FAIL ovf_count_after: got %0d exp 8", a_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (a_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_drain_valid[%0d]: got %0b exp 1", i, a_valid); end
      n_checks++; if (a_data !== 32'(100 + i)) begin n_errors++; $display("FAIL ovf_drain_data[%0d]: got %0d exp %0d", i, a_data, 100 + i); end
      n_checks++; if (a_tag !== 5'(i)) begin n_errors++; $display("FAIL ovf_drain_tag[%0d]: got %0d exp %0d", i, a_tag, i); end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained: got %0b exp 0", a_valid); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_valid = 1'b1; cap_data = 32'(200 + i); cap_tag = 5'd7;
      step();
    end
    cap_valid = 1'b0;
    n_checks++; if (a_full !== 1'b1) begin n_errors++; $display("FAIL fullpop_full: got %0b exp 1", a_full); end
    cap_valid = 1'b1; cap_data = 32'd999; out_ready = 1'b1;
    step();
    cap_valid = 1'b0;
    n_checks++; if (a_count !== 4'd7) begin n_errors++; $display("FAIL fullpop_count: got %0d exp 7", a_count); end
    n_checks++; if (a_drop !== 8'd3) begin n_errors++; $display("FAIL fullpop_drop: got %0d exp 3", a_drop); end
    n_checks++; if (a_full !== 1'b0) begin n_errors++; $display("FAIL fullpop_notfull: got %0b exp 0", a_full); end
    for (int i = 1; i < 8; i++) begin
      n_checks++; if (a_data !== 32'(200 + i)) begin n_errors++; $display("FAIL fullpop_data[%0d]: got %0d exp %0d", i, a_data, 200 + i); end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL fullpop_drained: got %0b exp 0", a_valid); end
  endtask

  task automatic test_backpressure();
    logic [36:0] q[$];
    int  sent = 0;
    int  got  = 0;
    int  cyc  = 0;
    logic rdy, psh;
    while ((sent < 20 || q.size() != 0) && cyc < 200) begin
      n_checks++; if (a_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL bp_valid[%0d]: got %0b exp %0b", cyc, a_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        n_checks++; if (a_data !== q[0][31:0]) begin n_errors++; $display("FAIL bp_data[%0d]: got %0d exp %0d", cyc, a_data, q[0][31:0]); end
        n_checks++; if (a_tag !== q[0][36:32]) begin n_errors++; $display("FAIL bp_tag[%0d]: got %0d exp %0d", cyc, a_tag, q[0][36:32]); end
      end
      rdy = ((cyc % 2) == 1);
      psh = (sent < 20) && (q.size() < 8);
      out_ready = rdy;
      cap_valid = psh;
      cap_data  = 32'(300 + sent);
      cap_tag   = 5'((sent * 3) % 32);
      step();
      if (rdy && q.size() != 0) begin void'(q.pop_front()); got++; end
      if (psh) begin q.push_back({5'((sent * 3) % 32), 32'(300 + sent)}); sent++; end
      cyc++;
    end
    cap_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (got != 20) begin n_errors++; $display("FAIL bp_received: got %0d exp 20", got); end
    n_checks++; if (a_drop !== 8'd3) begin n_errors++; $display("FAIL bp_nodrop: got %0d exp 3", a_drop); end
  endtask

  task automatic test_clear_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_valid = 1'b1; cap_data = 32'(400 + i); cap_tag = 5'd1;
      step();
    end
    clear_ovf = 1'b1; cap_data = 32'hdead;
    step();
    cap_valid = 1'b0;
    n_checks++; if (a_drop !== 8'd1) begin n_errors++; $display("FAIL clr_drop_wins: got %0d exp 1", a_drop); end
    n_checks++; if (a_ovf !== 1'b1) begin n_errors++; $display("FAIL clr_ovf_wins: got %0b exp 1", a_ovf); end
    step();
    clear_ovf = 1'b0;
    n_checks++; if (a_drop !== 8'd0) begin n_errors++; $display("FAIL clr_drop: got %0d exp 0", a_drop); end
    n_checks++; if (a_ovf !== 1'b0) begin n_errors++; $display("FAIL clr_ovf: got %0b exp 0", a_ovf); end
    cap_valid = 1'b1;
    step();
    cap_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    n_checks++; if (a_count !== 4'd5) begin n_errors++; $display("FAIL clr_count5: got %0d exp 5", a_count); end
    n_checks++; if (a_data !== 32'd403) begin n_errors++; $display("FAIL clr_head: got %0d exp 403", a_data); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b exp 0", a_valid); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL rst_count: got %0d exp 0", a_count); end
    n_checks++; if (a_full !== 1'b0) begin n_errors++; $display("FAIL rst_full: got %0b exp 0", a_full); end
    n_checks++; if (a_last !== 1'b0) begin n_errors++; $display("FAIL rst_last: got %0b exp 0", a_last); end
    n_checks++; if (a_ovf !== 1'b0) begin n_errors++; $display("FAIL rst_ovf: got %0b exp 0", a_ovf); end
    n_checks++; if (a_drop !== 8'd0) begin n_errors++; $display("FAIL rst_drop: got %0d exp 0", a_drop); end
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'b1; cap_data = 32'(500 + i); cap_tag = 5'(i + 8);
      step();
    end
    cap_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a_data !== 32'(500 + i)) begin n_errors++; $display("FAIL rst_data[%0d]: got %0d exp %0d", i, a_data, 500 + i); end
      n_checks++; if (a_last !== (i == 3)) begin n_errors++; $display("FAIL rst_frame_last[%0d]: got %0b exp %0b", i, a_last, (i == 3)); end
      n_checks++; if (b_last !== 1'b0) begin n_errors++; $display("FAIL rst_frame_last16[%0d]: got %0b exp 0", i, b_last); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_frame_wrap();
    #2 reset = 1'b0;
    #4 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cap_valid = 1'b1; cap_data = 32'(600 + i); cap_tag = 5'd2;
      step();
      n_checks++; if (b_data !== 32'(600 + i)) begin n_errors++; $display("FAIL wrap_data[%0d]: got %0d exp %0d", i, b_data, 600 + i); end
      n_checks++; if (b_last !== (i == 15)) begin n_errors++; $display("FAIL wrap_last16[%0d]: got %0b exp %0b", i, b_last, (i == 15)); end
      n_checks++; if (a_last !== ((i % 4) == 3)) begin n_errors++; $display("FAIL wrap_last4[%0d]: got %0b exp %0b", i, a_last, ((i % 4) == 3)); end
    end
    cap_valid = 1'b0;
    step();
    out_ready = 1'b0;
    n_checks++; if (b_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_empty: got %0b exp 0", b_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_backpressure();
    test_clear_reset();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/dsp_sample_drain.md
# dsp_sample_drain

Output-side sink for the single-cycle MIPS/DSP core. It captures every DSP filter result the CPU writes back, tagged with its `dspcontrol` opcode. It buffers the results in a small FIFO and streams them to a downstream consumer over a valid/ready handshake, with frame markers and overflow accounting. It sits beside `MipsCPU` and is driven from its `dspout`, `dspcontrol`, `dsporALU` and `RegWrite` signals.

## Interface
- `DATA_W`, 32, sample width (matches `dspout`)
- `TAG_W`, 5, tag width (matches `dspcontrol`)
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `FRAME_LEN`, 16, samples per output frame; ≥1
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cap_valid`  in  1  capture strobe (`RegWrite & dsporALU` at the core)
- `cap_data`  in  DATA_W  filtered sample (`dspout`)
- `cap_tag`  in  TAG_W  DSP opcode (`dspcontrol`)
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts the head entry
- `out_data`  out  DATA_W  head sample
- `out_tag`  out  TAG_W  head tag
- `out_last`  out  1  head entry closes a frame
- `full`  out  1  count == DEPTH
- `count`  out  $clog2(DEPTH)+1  occupancy
- `overflow`  out  1  sticky: at least one capture was dropped
- `drop_cnt`  out  8  dropped captures, saturating at 255
- `clear_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`

## Operation
- Push: `cap_valid & ~full` writes {tag, data} at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- Drop: `cap_valid & full` discards the sample. `overflow` is set to 1 and `drop_cnt` increments, saturating at 255.
- `full` uses the pre-edge count. A push while full is dropped even when a pop occurs on the same edge.
- Pop: `out_valid & out_ready` advances `rd_ptr` modulo DEPTH.
- Pop bookkeeping: each pop increments `frame_cnt` (0..FRAME_LEN-1), which wraps to 0 after FRAME_LEN-1.
- Occupancy: push-only gives count+1; pop-only gives count−1; push and pop together leave count unchanged.
- Output is first-word-fall-through: `out_valid = (count != 0)` and `out_data/out_tag = mem[rd_ptr]`.
- `out_last = out_valid & (frame_cnt == FRAME_LEN-1)`. With FRAME_LEN=1, every valid entry is last.
- Handshake rule: while `out_valid & ~out_ready`, `out_data`, `out_tag` and `out_last` must hold stable.
- `clear_ovf` zeroes `overflow` and `drop_cnt`. If a drop occurs on the same edge, the drop wins: `overflow`=1 and `drop_cnt`=1.
- No other control state. The logic is a counter-based FIFO plus the frame and drop counters.

## Timing
- Reset (asynchronous, `reset`=0) clears pointers, count, `frame_cnt`, `overflow` and `drop_cnt`.
- Output values during reset: `out_valid`=0, `full`=0, `count`=0, `out_last`=0, `overflow`=0, `drop_cnt`=0.
- `out_data`/`out_tag` are don't-care while `out_valid`=0; memory contents are not reset.
- Reset mid-stream discards all buffered entries and restarts the frame at position 0.
- Capture-to-output latency is 1 cycle. A sample pushed at edge N gives `out_valid`=1 after edge N.
- Throughput is one push and one pop per cycle. A full FIFO with `out_ready` held high drains DEPTH entries in DEPTH cycles.
- An empty FIFO with simultaneous `cap_valid` performs the push only; no bypass path exists.
- All outputs come from registers or from `mem[rd_ptr]`. No input→output combinational path exists except that `out_ready` has none.

## Structure
- Package `dsp_stream_pkg` holds the `DSP_DATA_W`=32 and `DSP_TAG_W`=5 constants.
- Package `dsp_stream_pkg` also holds the packed entry type {tag, data} and the `DROP_MAX`=255 constant.
- Sub-module `sync_fifo`, parameterised DATA_W/DEPTH, provides storage, pointers, count and full/empty.
- Frame counting, drop accounting and the clear logic live in the top `dsp_sample_drain`.

## Test plan
1. Basic capture: DEPTH=8, FRAME_LEN=4, `out_ready`=1. Capture data 10, 20, 30, 40 with tag 5'b00011. Required: output data 10, 20, 30, 40 in order, one cycle after each capture, with `out_last` only on 40.
2. Overflow: `out_ready`=0 and 10 consecutive captures. Required: `full`=1 and `count`=8 after 8 captures, then `overflow`=1 and `drop_cnt`=2; draining returns the first 8 values.
3. Full with simultaneous pop: FIFO full, `cap_valid` and `out_ready` on the same edge. Required: the capture is dropped, `count`=7, `drop_cnt`+1.
4. Backpressure: toggle `out_ready` every cycle across 20 samples. Required: data and tag stay stable while stalled, with no loss or duplication.
5. Frame wrap: pop 20 samples. Required: `out_last` on the 16th sample only.
6. Clear and reset: assert `clear_ovf` on the same edge as a drop. Required: `drop_cnt`=1. Then assert `reset`=0 mid-stream with count=5. Required: all outputs 0 immediately, and the next capture pops with frame position 0.
